// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Package    : mips_pkg
// Description: Shared constants and types for the MIPS decode-to-execute stage.
//              Holds the ALU control encodings, opcode/funct values, the
//              operand-B source selector, the skid-buffer state encoding and
//              the bundle type that carries every ALU input and its side-info.
// Revision   : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam int PKG_DATA_W = 32;
    localparam int PKG_REG_AW = 5;

    // ALU control encodings consumed by the EX stage
    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SUB = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;
    localparam logic [3:0] ALU_NOR = 4'd12;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    // Source of ALU operand B
    typedef enum logic [1:0] {
        BSEL_RT   = 2'd0,
        BSEL_SEXT = 2'd1,
        BSEL_ZEXT = 2'd2
    } bsel_e;

    // Skid-buffer occupancy: EMPTY (0 entries), FULL (main only), SKID (main + skid)
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } stage_state_e;

    typedef struct packed {
        logic [3:0]            alu_control;
        logic [PKG_DATA_W-1:0] alu_a;
        logic [PKG_DATA_W-1:0] alu_b;
        logic [PKG_DATA_W-1:0] store_data;
        logic [PKG_REG_AW-1:0] dest_reg;
        logic                  reg_write;
        logic                  is_load;
        logic                  is_store;
        logic                  is_branch;
        logic                  illegal;
    } ex_bundle_t;

    function automatic logic [PKG_DATA_W-1:0] sext16(input logic [15:0] v);
        return {{(PKG_DATA_W-16){v[15]}}, v};
    endfunction

    function automatic logic [PKG_DATA_W-1:0] zext16(input logic [15:0] v);
        return {{(PKG_DATA_W-16){1'b0}}, v};
    endfunction

endpackage : mips_pkg
`default_nettype wire

// File: rtl/mips_alu_decode.sv
`default_nettype none
// ============================================================================
// Module     : mips_alu_decode
// Description: Purely combinational instruction decoder. Maps opcode/funct to
//              the 4-bit ALU control code, selects operand B (rt, sign- or
//              zero-extended immediate) and derives the writeback/memory flags.
//              Unsupported encodings produce a bundle with only illegal set
//              (plus the raw operands) so they still flow down the pipe.
// Ports      : instr_i    - 32-bit instruction word
//              rs_data_i  - register read port A (becomes alu_a)
//              rt_data_i  - register read port B (store data / operand B)
//              bundle_o   - decoded ALU inputs and side-info
// Revision   : 1.0 - initial release
// ============================================================================
module mips_alu_decode
    import mips_pkg::*;
(
    input  logic [31:0]           instr_i,
    input  logic [PKG_DATA_W-1:0] rs_data_i,
    input  logic [PKG_DATA_W-1:0] rt_data_i,
    output ex_bundle_t            bundle_o
);

    logic [5:0]            opcode;
    logic [5:0]            funct;
    logic [PKG_REG_AW-1:0] rt_idx;
    logic [PKG_REG_AW-1:0] rd_idx;
    logic [15:0]           imm;

    assign opcode = instr_i[31:26];
    assign funct  = instr_i[5:0];
    assign rt_idx = instr_i[20:16];
    assign rd_idx = instr_i[15:11];
    assign imm    = instr_i[15:0];

    // The rs index is resolved by the register file upstream; only its data is used here.
    logic unused_rs_idx;
    assign unused_rs_idx = ^instr_i[25:21];

    logic [3:0] ctrl;
    logic       legal;
    logic       wr;
    logic       use_rd;
    bsel_e      bsel;
    logic       ld;
    logic       st;
    logic       br;

    always_comb begin
        ctrl   = ALU_AND;
        legal  = 1'b0;
        wr     = 1'b0;
        use_rd = 1'b0;
        bsel   = BSEL_RT;
        ld     = 1'b0;
        st     = 1'b0;
        br     = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                use_rd = 1'b1;
                case (funct)
                    FN_ADD, FN_ADDU: begin ctrl = ALU_ADD; legal = 1'b1; wr = 1'b1; end
                    FN_SUB, FN_SUBU: begin ctrl = ALU_SUB; legal = 1'b1; wr = 1'b1; end
                    FN_AND:          begin ctrl = ALU_AND; legal = 1'b1; wr = 1'b1; end
                    FN_OR:           begin ctrl = ALU_OR;  legal = 1'b1; wr = 1'b1; end
                    FN_NOR:          begin ctrl = ALU_NOR; legal = 1'b1; wr = 1'b1; end
                    FN_SLT:          begin ctrl = ALU_SLT; legal = 1'b1; wr = 1'b1; end
                    default:         ;
                endcase
            end
            OP_ADDI, OP_ADDIU: begin ctrl = ALU_ADD; legal = 1'b1; wr = 1'b1; bsel = BSEL_SEXT; end
            OP_SLTI:           begin ctrl = ALU_SLT; legal = 1'b1; wr = 1'b1; bsel = BSEL_SEXT; end
            OP_ANDI:           begin ctrl = ALU_AND; legal = 1'b1; wr = 1'b1; bsel = BSEL_ZEXT; end
            OP_ORI:            begin ctrl = ALU_OR;  legal = 1'b1; wr = 1'b1; bsel = BSEL_ZEXT; end
            OP_LW:  begin ctrl = ALU_ADD; legal = 1'b1; wr = 1'b1; bsel = BSEL_SEXT; ld = 1'b1; end
            OP_SW:  begin ctrl = ALU_ADD; legal = 1'b1; bsel = BSEL_SEXT; st = 1'b1; end
            OP_BEQ: begin ctrl = ALU_SUB; legal = 1'b1; br = 1'b1; end
            default: ;
        endcase
    end

    always_comb begin
        bundle_o             = '0;
        bundle_o.alu_a       = rs_data_i;
        bundle_o.store_data  = rt_data_i;
        bundle_o.alu_control = legal ? ctrl : ALU_AND;
        bundle_o.reg_write   = legal & wr;
        bundle_o.is_load     = legal & ld;
        bundle_o.is_store    = legal & st;
        bundle_o.is_branch   = legal & br;
        bundle_o.illegal     = ~legal;
        case (bsel)
            BSEL_SEXT: bundle_o.alu_b = sext16(imm);
            BSEL_ZEXT: bundle_o.alu_b = zext16(imm);
            default:   bundle_o.alu_b = rt_data_i;
        endcase
        // Non-writing instructions report register 0 so hazard logic never matches them.
        if (legal && wr) begin
            bundle_o.dest_reg = use_rd ? rd_idx : rt_idx;
        end
    end

endmodule : mips_alu_decode
`default_nettype wire

// File: rtl/mips_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module     : mips_id_ex_stage
// Description: Decode-to-execute pipeline stage. Decodes the incoming
//              instruction and registers all ALU inputs plus side-info behind
//              a two-entry skid buffer (main + skid register), giving full
//              throughput with an in_ready that depends only on state.
// Ports      : clk, rst_n (sync, active-low), flush_i (squash everything)
//              in_valid_i / in_ready_o, instr_i, rs_data_i, rt_data_i
//              out_valid_o / out_ready_i, alu_control_o, alu_a_o, alu_b_o,
//              store_data_o, dest_reg_o, reg_write_o, is_load_o, is_store_o,
//              is_branch_o, illegal_o
// Revision   : 1.0 - initial release
// ============================================================================
module mips_id_ex_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = PKG_DATA_W,
    parameter int REG_AW = PKG_REG_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [31:0]       instr_i,
    input  logic [DATA_W-1:0] rs_data_i,
    input  logic [DATA_W-1:0] rt_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [3:0]        alu_control_o,
    output logic [DATA_W-1:0] alu_a_o,
    output logic [DATA_W-1:0] alu_b_o,
    output logic [DATA_W-1:0] store_data_o,
    output logic [REG_AW-1:0] dest_reg_o,
    output logic              reg_write_o,
    output logic              is_load_o,
    output logic              is_store_o,
    output logic              is_branch_o,
    output logic              illegal_o
);

    ex_bundle_t   dec_bundle;
    ex_bundle_t   main_q;
    ex_bundle_t   main_d;
    ex_bundle_t   skid_q;
    ex_bundle_t   skid_d;
    stage_state_e state_q;
    stage_state_e state_d;
    logic         accept;

    mips_alu_decode u_decode (
        .instr_i   (instr_i),
        .rs_data_i (rs_data_i),
        .rt_data_i (rt_data_i),
        .bundle_o  (dec_bundle)
    );

    // in_ready comes straight from the state register (plus reset gating),
    // so there is no combinational path from out_ready back upstream.
    assign in_ready_o  = (state_q != ST_SKID) & rst_n;
    assign out_valid_o = (state_q != ST_EMPTY);
    assign accept      = in_valid_i & in_ready_o;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    main_d  = dec_bundle;
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (accept && out_ready_i) begin
                    main_d = dec_bundle;
                end else if (accept) begin
                    // Consumer stalled: park the new entry so main stays stable.
                    skid_d  = dec_bundle;
                    state_d = ST_SKID;
                end else if (out_ready_i) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_SKID: begin
                if (out_ready_i) begin
                    main_d  = skid_q;
                    state_d = ST_FULL;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // A squash empties the buffer; stale data stays put but is never marked valid.
        if (flush_i) begin
            state_d = ST_EMPTY;
            main_d  = main_q;
            skid_d  = skid_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    assign alu_control_o = main_q.alu_control;
    assign alu_a_o       = main_q.alu_a;
    assign alu_b_o       = main_q.alu_b;
    assign store_data_o  = main_q.store_data;
    assign dest_reg_o    = main_q.dest_reg;
    assign reg_write_o   = main_q.reg_write;
    assign is_load_o     = main_q.is_load;
    assign is_store_o    = main_q.is_store;
    assign is_branch_o   = main_q.is_branch;
    assign illegal_o     = main_q.illegal;

endmodule : mips_id_ex_stage
`default_nettype wire

// File: tb/tb_mips_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module     : tb_mips_id_ex_stage
// Description: Self-checking bench for mips_id_ex_stage. A queue-based
//              reference model tracks the ordered in-flight instructions and a
//              table-driven decoder predicts each decoded bundle.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_mips_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] instr_i;
    logic [31:0] rs_data_i;
    logic [31:0] rt_data_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [3:0]  alu_control_o;
    logic [31:0] alu_a_o;
    logic [31:0] alu_b_o;
    logic [31:0] store_data_o;
    logic [4:0]  dest_reg_o;
    logic        reg_write_o;
    logic        is_load_o;
    logic        is_store_o;
    logic        is_branch_o;
    logic        illegal_o;

    always #5 clk = ~clk;

    mips_id_ex_stage #(.DATA_W(32), .REG_AW(5)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush_i       (flush_i),
        .in_valid_i    (in_valid_i),
        .in_ready_o    (in_ready_o),
        .instr_i       (instr_i),
        .rs_data_i     (rs_data_i),
        .rt_data_i     (rt_data_i),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .alu_control_o (alu_control_o),
        .alu_a_o       (alu_a_o),
        .alu_b_o       (alu_b_o),
        .store_data_o  (store_data_o),
        .dest_reg_o    (dest_reg_o),
        .reg_write_o   (reg_write_o),
        .is_load_o     (is_load_o),
        .is_store_o    (is_store_o),
        .is_branch_o   (is_branch_o),
        .illegal_o     (illegal_o)
    );

    typedef struct {
        int unsigned ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sd;
        int unsigned dest;
        bit          wr;
        bit          ld;
        bit          st;
        bit          br;
        bit          ill;
    } exp_t;

    exp_t mq[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Decode prediction straight from the instruction table.
    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] ra, input logic [31:0] rb);
        exp_t        e;
        int unsigned op;
        int unsigned fn;
        int unsigned rt;
        int unsigned rd;
        int unsigned imm;
        logic [31:0] sx;
        logic [31:0] zx;
        bit          ok;
        op  = int'(ins >> 26) & 63;
        fn  = int'(ins) & 63;
        rt  = int'(ins >> 16) & 31;
        rd  = int'(ins >> 11) & 31;
        imm = int'(ins) & 32'hFFFF;
        zx  = imm;
        sx  = (imm >= 32'h8000) ? (imm | 32'hFFFF0000) : imm;
        e = '{ctrl: 0, a: ra, b: rb, sd: rb, dest: 0, wr: 0, ld: 0, st: 0, br: 0, ill: 0};
        ok = 1;
        if (op == 0) begin
            e.dest = rd; e.wr = 1;
            if (fn == 32 || fn == 33)      e.ctrl = 2;
            else if (fn == 34 || fn == 35) e.ctrl = 6;
            else if (fn == 36)             e.ctrl = 0;
            else if (fn == 37)             e.ctrl = 1;
            else if (fn == 39)             e.ctrl = 12;
            else if (fn == 42)             e.ctrl = 7;
            else                           ok = 0;
        end else if (op == 8 || op == 9) begin e.ctrl = 2; e.b = sx; e.dest = rt; e.wr = 1;
        end else if (op == 10) begin e.ctrl = 7; e.b = sx; e.dest = rt; e.wr = 1;
        end else if (op == 12) begin e.ctrl = 0; e.b = zx; e.dest = rt; e.wr = 1;
        end else if (op == 13) begin e.ctrl = 1; e.b = zx; e.dest = rt; e.wr = 1;
        end else if (op == 35) begin e.ctrl = 2; e.b = sx; e.dest = rt; e.wr = 1; e.ld = 1;
        end else if (op == 43) begin e.ctrl = 2; e.b = sx; e.st = 1;
        end else if (op == 4)  begin e.ctrl = 6; e.br = 1;
        end else ok = 0;
        if (!ok) begin
            e.ctrl = 0; e.dest = 0; e.wr = 0; e.ld = 0; e.st = 0; e.br = 0; e.ill = 1;
        end
        return e;
    endfunction

    // Clock-edge view of the stage: an ordered queue of at most two entries.
    task automatic model_update();
        bit rdy;
        bit vld;
        if (!rst_n) begin
            mq.delete();
        end else begin
            rdy = (mq.size() < 2);
            vld = (mq.size() != 0);
            if (vld && out_ready_i) mq.delete(0);
            if (flush_i) mq.delete();
            else if (in_valid_i && rdy) mq.push_back(ref_decode(instr_i, rs_data_i, rt_data_i));
        end
    endtask

    task automatic check_outputs();
        exp_t e;
        chk("in_ready", 64'(in_ready_o), 64'(rst_n && (mq.size() < 2)));
        chk("out_valid", 64'(out_valid_o), 64'(mq.size() != 0));
        if (mq.size() != 0) begin
            e = mq[0];
            chk("alu_control", 64'(alu_control_o), 64'(e.ctrl));
            chk("alu_a", 64'(alu_a_o), 64'(e.a));
            if (!e.ill) chk("alu_b", 64'(alu_b_o), 64'(e.b));
            chk("store_data", 64'(store_data_o), 64'(e.sd));
            chk("dest_reg", 64'(dest_reg_o), 64'(e.dest));
            chk("reg_write", 64'(reg_write_o), 64'(e.wr));
            chk("flags", 64'({is_load_o, is_store_o, is_branch_o, illegal_o}),
                64'({e.ld, e.st, e.br, e.ill}));
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        in_valid_i = v;
        instr_i    = ins;
        rs_data_i  = a;
        rt_data_i  = b;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0] fns [8];
        logic [5:0] ops [8];
        logic [31:0] w;
        int k;
        fns = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27, 6'h2A};
        ops = '{6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h23, 6'h2B, 6'h04};
        w = $urandom;
        k = $urandom_range(0, 9);
        if (k < 4)       w = {6'h00, w[25:6], fns[$urandom_range(0, 7)]};
        else if (k < 8)  w = {ops[$urandom_range(0, 7)], w[25:0]};
        else if (k == 8) w = {6'h00, w[25:0]};
        return w;
    endfunction

    initial begin
        rst_n = 1'b0; flush_i = 1'b0; out_ready_i = 1'b1;
        drive(1'b1, 32'h00221820, 32'd5, 32'd7);

        // Reset held three cycles with valid input pending
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("rst_out_valid", 64'(out_valid_o), 64'd0);
            chk("rst_in_ready", 64'(in_ready_o), 64'd0);
        end
        chk("rst_alu_a", 64'(alu_a_o), 64'd0);
        chk("rst_ctrl_dest", 64'({alu_control_o, dest_reg_o, reg_write_o, illegal_o}), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", 64'(in_ready_o), 64'd1);

        // add $3,$1,$2
        cycle();
        chk("add_ctrl", 64'(alu_control_o), 64'd2);
        chk("add_a_b", 64'({alu_a_o, alu_b_o}), {32'd5, 32'd7});
        chk("add_dest", 64'({dest_reg_o, reg_write_o}), 64'({5'd3, 1'b1}));

        // andi / addi with all-ones immediate
        drive(1'b1, 32'h3024FFFF, 32'd9, 32'd1);
        cycle();
        chk("andi_ctrl", 64'(alu_control_o), 64'd0);
        chk("andi_b", 64'(alu_b_o), 64'h0000FFFF);
        drive(1'b1, 32'h2024FFFF, 32'd9, 32'd1);
        cycle();
        chk("addi_ctrl", 64'(alu_control_o), 64'd2);
        chk("addi_b", 64'(alu_b_o), 64'hFFFFFFFF);
        chk("addi_dest", 64'(dest_reg_o), 64'd4);

        // Drain, then fill both entries while EX stalls
        drive(1'b0, 32'h0, 32'd0, 32'd0);
        cycle();
        out_ready_i = 1'b0;
        drive(1'b1, 32'h00221820, 32'd11, 32'd22);
        cycle();
        drive(1'b1, 32'h34451234, 32'd33, 32'd44);
        cycle();
        chk("skid_in_ready", 64'(in_ready_o), 64'd0);
        chk("skid_holds_a", 64'(alu_a_o), 64'd11);
        drive(1'b0, 32'h0, 32'd0, 32'd0);
        out_ready_i = 1'b1;
        cycle();
        chk("skid_pop_b", 64'({alu_a_o, alu_b_o}), {32'd33, 32'h00001234});
        chk("skid_pop_in_ready", 64'(in_ready_o), 64'd1);

        // Flush while in SKID with a valid input present
        out_ready_i = 1'b0;
        drive(1'b1, 32'h00430820, 32'd1, 32'd2);
        cycle();
        drive(1'b1, 32'h00641020, 32'd3, 32'd4);
        cycle();
        chk("pre_flush_in_ready", 64'(in_ready_o), 64'd0);
        flush_i = 1'b1;
        cycle();
        chk("flush_out_valid", 64'(out_valid_o), 64'd0);
        chk("flush_in_ready", 64'(in_ready_o), 64'd1);
        flush_i = 1'b0;
        drive(1'b0, 32'h0, 32'd0, 32'd0);
        cycle();
        chk("flush_discard", 64'(out_valid_o), 64'd0);

        // Unsupported opcode still flows through
        out_ready_i = 1'b1;
        drive(1'b1, 32'hFC000000, 32'd7, 32'd8);
        cycle();
        chk("illegal_flag", 64'({out_valid_o, illegal_o, reg_write_o}), 64'({1'b1, 1'b1, 1'b0}));
        chk("illegal_ctrl", 64'(alu_control_o), 64'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst_n       = ($urandom_range(0, 249) != 0);
            flush_i     = ($urandom_range(0, 19) == 0);
            out_ready_i = ($urandom_range(0, 2) != 0);
            drive(($urandom_range(0, 3) != 0), rand_instr(), $urandom, $urandom);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_mips_id_ex_stage
`default_nettype wire
